// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
package gcd_pkg;

  // Default operand and result width
  localparam int GCD_WIDTH = 8;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_step.sv
// One step of subtractive Euclid as pure combinational logic.
// The checks run in priority order:
//   a == 0  -> done, result b
//   b == 0  -> done, result a
//   a == b  -> done, result a
//   a >  b  -> a - b
//   else    -> b - a
// The larger operand is always the minuend, so the WIDTH-bit unsigned
// difference never wraps.
import gcd_pkg::*;

module gcd_step #(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Priority compare/subtract; operands pass through unchanged when done
  always_comb begin
    a_next = a;
    b_next = b;
    done   = 1'b0;
    result = '0;
    if (a == '0) begin
      done   = 1'b1;
      result = b;
    end else if (b == '0) begin
      done   = 1'b1;
      result = a;
    end else if (a == b) begin
      done   = 1'b1;
      result = a;
    end else if (a > b) begin
      a_next = a - b;
    end else begin
      b_next = b - a;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Sequential GCD engine.
// - Takes an operand pair over a valid/ready handshake.
// - Performs one Euclid step per clock.
// - Returns the result over a valid/ready handshake.
// Optional macro GCD_CYCLE_CNT_EN adds the cycles_out port, which reports
// the number of CALC cycles spent on the current result.
import gcd_pkg::*;

module gcd_engine #(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out
`ifdef GCD_CYCLE_CNT_EN
  ,
  output logic [WIDTH-1:0] cycles_out
`endif
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] b_step;
  logic [WIDTH-1:0] step_result;
  logic             step_done;
  logic             in_fire;
  logic             out_fire;
  logic             calc;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a      (a_reg),
    .b      (b_reg),
    .a_next (a_step),
    .b_next (b_step),
    .done   (step_done),
    .result (step_result)
  );

  // Handshake strobes and outputs decoded from state
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign calc      = (state == CALC);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign gcd_out   = result_reg;

  // Next-state logic for IDLE -> CALC -> DONE -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire)   state_next = CALC;
      CALC:    if (step_done) state_next = DONE;
      DONE:    if (out_fire)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand registers: captured on accept, updated by each Euclid step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (in_fire) begin
      a_reg <= a_in;
      b_reg <= b_in;
    end else if (calc && !step_done) begin
      a_reg <= a_step;
      b_reg <= b_step;
    end
  end

  // Result register: loaded when CALC finishes, then kept until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else if (calc && step_done) begin
      result_reg <= step_result;
    end
  end

`ifdef GCD_CYCLE_CNT_EN
  logic [WIDTH-1:0] cycle_cnt;

  // CALC-cycle counter:
  // - clears on accept
  // - counts every CALC cycle, including the final one
  // - saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (in_fire) begin
      cycle_cnt <= '0;
    end else if (calc && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign cycles_out = cycle_cnt;
`else
  // Cycle counting not built; no counter and no cycles_out port.
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine.
// Stimulus pushes the expected result, latency and cycle count into a queue.
// A separate monitor pops and compares them at each output handshake.
`timescale 1ns/1ps

module tb_gcd_engine;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] g;
    int           lat;  // -1: latency not checked
    int           cy;   // -1: cycle count not checked
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] gcd_out;
`ifdef GCD_CYCLE_CNT_EN
  logic [W-1:0] cycles_out;
`endif

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           hs_cyc = 0;
  logic         prev_ov = 1'b0;
  logic [W-1:0] held_g = '0;

  gcd_engine #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gcd_out    (gcd_out)
`ifdef GCD_CYCLE_CNT_EN
    ,
    .cycles_out (cycles_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic logic [W-1:0] sw_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    int q;
    int t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p[W-1:0];
  endfunction

  // Monitor: checks latency on the out_valid rise, holding while stalled,
  // and result values at each output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) hs_cyc = cyc;
      if (out_valid) chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%0d required=none", gcd_out);
        end else if (exp_q[0].lat >= 0) begin
          chk("latency", cyc - hs_cyc - 1, exp_q[0].lat);
        end
      end
      if (out_valid && prev_ov) chk("hold_gcd", {24'd0, gcd_out}, {24'd0, held_g});
      if (out_valid && out_ready && exp_q.size() > 0) begin
        chk("gcd", {24'd0, gcd_out}, {24'd0, exp_q[0].g});
`ifdef GCD_CYCLE_CNT_EN
        if (exp_q[0].cy >= 0) chk("cycles_out", {24'd0, cycles_out}, exp_q[0].cy);
`endif
        void'(exp_q.pop_front());
      end
      prev_ov = out_valid;
      held_g  = gcd_out;
    end
  end

  // Present a pair, wait for acceptance, optionally record the expectation
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] g, input int lat, input int cy,
                      input bit push, input bit hold);
    int n;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end else begin
      @(posedge clk);
      #1;
      if (push) exp_q.push_back('{g, lat, cy});
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Wait until every expected result has been seen
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 2000)) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_gcd_out", {24'd0, gcd_out}, 32'd0);
`ifdef GCD_CYCLE_CNT_EN
    chk("rst_cycles_out", {24'd0, cycles_out}, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results
    send(8'd12, 8'd18, 8'd6, 3, 3, 1'b1, 1'b0);
    drain();
    send(8'd0, 8'd0, 8'd0, 1, 1, 1'b1, 1'b0);
    drain();
    send(8'd0, 8'd35, 8'd35, 1, 1, 1'b1, 1'b0);
    drain();
    send(8'd35, 8'd0, 8'd35, 1, 1, 1'b1, 1'b0);
    drain();
    send(8'd255, 8'd1, 8'd1, 255, 255, 1'b1, 1'b0);
    drain();
    send(8'd17, 8'd5, 8'd1, 7, 7, 1'b1, 1'b0);
    drain();

    // Backpressure: the result is held while stalled, and a stray pair is ignored
    out_ready = 1'b0;
    send(8'd48, 8'd36, 8'd12, 4, 4, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    a_in     = 8'd7;
    b_in     = 8'd7;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_gcd_held", {24'd0, gcd_out}, 32'd12);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("bp_gcd_kept", {24'd0, gcd_out}, 32'd12);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_extra", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset during CALC discards the result in flight
    send(8'd200, 8'd3, 8'd1, -1, -1, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_gcd_out", {24'd0, gcd_out}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_gcd_out", {24'd0, gcd_out}, 32'd0);
    @(posedge clk);
    #1;
    send(8'd9, 8'd6, 8'd3, 3, 3, 1'b1, 1'b0);
    drain();

    // Back-to-back pairs with in_valid held high throughout
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom_range(1, 255));
      rb = 8'($urandom_range(1, 255));
      send(ra, rb, sw_gcd(ra, rb), -1, -1, 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
